fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that owns the program counter and feeds decode.
- Downstream consumer of the branch comparator's br_taken decision; the redirect target arrives alongside it from execute.
- Issues word fetches to instruction memory over a valid/ready request channel, with at most one request outstanding.
- Buffers returned instructions in a 2-entry FIFO toward decode; flushes the FIFO and discards in-flight data on redirect.

Parameters:
- RESET_PC, 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- BUF_DEPTH, 2: fetch buffer entries; legal values are 2 or 4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- br_taken  in  1  conditional branch resolved taken, from branch comparator
- br_target  in  32  branch destination (pc_ex + imm_b)
- jump  in  1  JAL/JALR in execute
- jump_target  in  32  jump destination
- stall  in  1  hazard unit: suppress new requests
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address of the request
- imem_resp_valid  in  1  instruction returned; in-order, exactly one per accepted request
- imem_resp_data  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts
- if_pc  out  32  PC of the head instruction
- if_pc_plus4  out  32  if_pc + 4, mod 2^32
- if_instr  out  32  head instruction
- misaligned_fault  out  1  one-cycle pulse: redirect target[1:0] != 0

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, FIFO empty, state=FETCH.
  - Outputs: if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), misaligned_fault=0.
  - imem_req_valid=0 while rst is asserted.
- FSM states: FETCH (no request outstanding), WAIT (one request outstanding), DRAIN (outstanding response is stale and must be dropped).
- Issue rule:
  - imem_req_valid = (state==FETCH) & !stall & (count + 0 < BUF_DEPTH). The credit check reserves a slot for the response.
  - imem_req_addr = pc.
- Request handshake (valid & ready):
  - pc <= pc + 4; 32'hFFFF_FFFC wraps to 0.
  - Request records its PC in req_pc; FETCH -> WAIT.
- WAIT + imem_resp_valid:
  - Push {req_pc, resp_data} into the FIFO; WAIT -> FETCH.
  - A new request may issue in the following cycle.
- DRAIN + imem_resp_valid: response discarded; DRAIN -> FETCH.
- Redirect (redirect = br_taken | jump):
  - br_taken has priority when both are asserted; target = br_target, otherwise jump_target.
  - pc <= {target[31:2], 2'b00}. If target[1:0] != 0, misaligned_fault pulses for that cycle.
  - FIFO flushed, count=0; flush wins over a simultaneous pop or push.
  - WAIT -> DRAIN. A request handshaking in the redirect cycle is stale: go to DRAIN.
  - A response arriving in the redirect cycle is dropped; state -> FETCH unless a new stale request also handshook.
  - Redirect overrides stall and the issue check: no request issues in the redirect cycle. The first request to the target issues in the next cycle when in FETCH.
- Decode side:
  - if_valid = count != 0; outputs come from the FIFO head register.
  - Pop on if_valid & if_ready.
  - Push and pop in the same cycle keep count unchanged.
  - The response-to-if_valid latency is 1 cycle, because the FIFO is registered.
- Stall only gates new requests. Outstanding responses are still accepted and buffered.
- Full FIFO: the credit rule guarantees it never overflows. A push into a full FIFO is an assertion failure.
- Reset mid-operation: all state is cleared asynchronously. The imem side is reset together with this block, so no stale response follows.

Decomposition:
- Shared package core_pkg:
  - OPC_BRANCH=7'b1100011, OPC_JAL, OPC_JALR, NOP_INSTR=32'h0000_0013.
  - fetch_state_t enum {FETCH, WAIT, DRAIN}.
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_buffer:
  - Parameterised BUF_DEPTH FIFO of fetch_entry_t with push, pop, flush, count, and registered head.

Test Plan:
- Reset release, memory ready with 1-cycle response:
  - imem_req_addr sequence 0x0, 0x4, 0x8, 0xC.
  - if_pc follows the same sequence; if_pc_plus4 = if_pc + 4.
- br_taken=1, br_target=0x100 while WAIT on the request for 0x8:
  - Response for 0x8 dropped; FIFO empty.
  - Next imem_req_addr=0x100; first if_pc after the redirect = 0x100.
- if_ready=0 for 10 cycles:
  - Count saturates at 2 and imem_req_valid stays 0.
  - When if_ready rises, if_pc drains in order with no lost or duplicate entry.
- jump=1, jump_target=0x202:
  - misaligned_fault pulses exactly 1 cycle; next request address = 0x200.
- br_taken and jump asserted together (0x40 / 0x80):
  - Next request address = 0x40.
- pc=0xFFFF_FFFC:
  - Next request address = 0x0.
- rst asserted mid-WAIT:
  - Outputs return to reset values immediately; first request after release is to RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, fetch FSM states and the fetch buffer payload.
package core_pkg;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Shift-register FIFO of fetched instructions; entry 0 is the registered head seen by decode.
module fetch_buffer
  import core_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  q   [BUF_DEPTH];
  fetch_entry_t  q_n [BUF_DEPTH];
  logic [CW-1:0] count_n;
  logic          do_pop;
  logic          do_push;
  logic          full;

  assign full    = (count == CW'(BUF_DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign head    = q[0];

  // Pop shifts toward the head; push lands just past the surviving entries.
  always_comb begin
    q_n     = q;
    count_n = count;
    if (do_pop) begin
      for (int i = 0; i < int'(BUF_DEPTH) - 1; i++) begin
        q_n[i] = q[i+1];
      end
      count_n = count - CW'(1);
    end
    if (do_push) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        if (CW'(i) == count_n) begin
          q_n[i] = push_entry;
        end
      end
      count_n = count_n + CW'(1);
    end
    if (flush) begin
      q_n     = q;
      count_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        q[i] <= '{pc: 32'h0, instr: NOP_INSTR};
      end
      count <= '0;
    end else begin
      q     <= q_n;
      count <= count_n;
    end
  end

  // The issue credit check makes a push into a full buffer impossible.
  assert property (@(posedge clk) disable iff (rst) !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests,
// buffers returned words toward decode and restarts on branch/jump redirects.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0]  RESET_PC  = 32'h0000_0000,
  parameter int unsigned  BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        misaligned_fault
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  fetch_state_t  state;
  fetch_state_t  state_n;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [31:0]   target;
  logic          redirect;
  logic          req_fire;
  logic          resp_accept;
  logic          pop;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign redirect = br_taken | jump;
  assign target   = br_taken ? br_target : jump_target;

  // A free buffer slot is reserved for the response before a request may issue.
  assign imem_req_valid = !rst && !redirect && (state == FETCH) && !stall
                          && (count < CW'(BUF_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign resp_accept    = (state == WAIT) & imem_resp_valid & !redirect;
  assign push_entry     = '{pc: req_pc, instr: imem_resp_data};

  assign if_valid    = (count != '0);
  assign pop         = if_valid & if_ready;
  assign if_pc       = head.pc;
  assign if_instr    = head.instr;
  assign if_pc_plus4 = head.pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_n;
    end
  end

  // A redirect while a response is still owed turns that response stale.
  always_comb begin
    state_n = state;
    case (state)
      FETCH: begin
        if (req_fire) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          state_n = FETCH;
        end else if (redirect) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_resp_valid) begin
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc               <= RESET_PC;
      req_pc           <= RESET_PC;
      misaligned_fault <= 1'b0;
    end else begin
      misaligned_fault <= redirect && (target[1:0] != 2'b00);
      if (redirect) begin
        pc <= word_align(target);
      end else if (req_fire) begin
        pc <= pc + 32'd4;
      end
      if (req_fire) begin
        req_pc <= pc;
      end
    end
  end

  fetch_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (resp_accept),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .head       (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a program-order reference model with a
// single-outstanding instruction memory model.
module tb_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        misaligned_fault;

  fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .jump             (jump),
    .jump_target      (jump_target),
    .stall            (stall),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_pc            (if_pc),
    .if_pc_plus4      (if_pc_plus4),
    .if_instr         (if_instr),
    .misaligned_fault (misaligned_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: program-order PCs for requests and for decode, buffered count.
  logic [31:0] exp_req = 32'h0;
  logic [31:0] exp_dec = 32'h0;
  int          mcount = 0;
  int          epoch = 0;
  logic        fault_exp = 1'b0;
  int          fault_cnt = 0;

  // Memory model: at most one pending response, tagged with the redirect epoch.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_ep = 0;
  int          pend_dly = 0;
  int          lat_min = 0;
  int          lat_max = 0;

  logic        hs_seen = 1'b0;
  logic [31:0] hs_addr = 32'h0;
  logic        pop_seen = 1'b0;
  logic [31:0] pop_pc = 32'h0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic rdy, input logic ird,
                      input logic bt, input logic [31:0] btg,
                      input logic jp, input logic [31:0] jtg);
    logic resp_now, redir, hs, pop, push_ok, exp_rv;
    logic [31:0] tgt;
    @(negedge clk);
    stall          = st;
    imem_req_ready = rdy;
    if_ready       = ird;
    br_taken       = bt;
    br_target      = btg;
    jump           = jp;
    jump_target    = jtg;
    resp_now        = pend && (pend_dly == 0);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? memf(pend_addr) : $urandom;
    #1;
    redir  = bt | jp;
    exp_rv = !pend && !st && (mcount < DEPTH) && !redir;
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check("if_valid", 32'(if_valid), 32'(mcount != 0));
    check("misaligned_fault", 32'(misaligned_fault), 32'(fault_exp));
    if (misaligned_fault) fault_cnt++;
    hs  = imem_req_valid & rdy;
    pop = if_valid & ird;
    if (pop) begin
      check("if_pc", if_pc, exp_dec);
      check("if_instr", if_instr, memf(exp_dec));
      check("if_pc_plus4", if_pc_plus4, exp_dec + 32'd4);
      pop_seen = 1'b1;
      pop_pc   = if_pc;
      exp_dec  = exp_dec + 32'd4;
    end
    if (hs) begin
      check("req_addr", imem_req_addr, exp_req);
      hs_seen = 1'b1;
      hs_addr = imem_req_addr;
    end
    push_ok = resp_now && (pend_ep == epoch) && !redir;
    if (resp_now) pend = 1'b0;
    else if (pend) pend_dly--;
    if (hs) begin
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      pend_ep   = epoch;
      pend_dly  = $urandom_range(lat_max, lat_min);
      exp_req   = exp_req + 32'd4;
    end
    if (redir) begin
      tgt       = bt ? btg : jtg;
      exp_req   = {tgt[31:2], 2'b00};
      exp_dec   = exp_req;
      mcount    = 0;
      epoch++;
      fault_exp = (tgt[1:0] != 2'b00);
    end else begin
      mcount    = mcount + int'(push_ok) - int'(pop);
      fault_exp = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic run_until_hs(input string tag, input logic [31:0] exp);
    hs_seen = 1'b0;
    for (int i = 0; i < 30 && !hs_seen; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    if (hs_seen) check(tag, hs_addr, exp);
    else check({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic run_until_pop(input string tag, input logic [31:0] exp);
    pop_seen = 1'b0;
    for (int i = 0; i < 30 && !pop_seen; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    if (pop_seen) check(tag, pop_pc, exp);
    else check({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic wait_pending(input string tag, input logic [31:0] addr, input logic any_addr);
    for (int i = 0; i < 40 && !(pend && (any_addr || pend_addr == addr)); i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    if (!(pend && (any_addr || pend_addr == addr))) check({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
    check({tag, "_if_valid"}, 32'(if_valid), 32'h0);
    check({tag, "_if_pc"}, if_pc, 32'h0);
    check({tag, "_if_instr"}, if_instr, NOP);
    check({tag, "_fault"}, 32'(misaligned_fault), 32'h0);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0:       t = $urandom & 32'h0000_0FFC;
      1:       t = $urandom & 32'h0000_0FFF;
      2:       t = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
      default: t = $urandom;
    endcase
    return t;
  endfunction

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch with a one-cycle memory; the model checks 0,4,8,C order.
    lat_min = 0; lat_max = 0;
    run_until_pop("seq_first_pc", 32'h0);
    idle(8);

    // Branch while waiting on the response for 0x8 drops it.
    @(negedge clk); rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    pend = 1'b0; exp_req = 32'h0; exp_dec = 32'h0; mcount = 0; epoch++; fault_exp = 1'b0;
    @(negedge clk); rst = 1'b0;
    lat_min = 2; lat_max = 2;
    wait_pending("wait8", 32'h8, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    lat_min = 0; lat_max = 0;
    run_until_hs("redir_addr", 32'h100);
    run_until_pop("redir_first_pc", 32'h100);

    // Decode backpressure: buffer fills, requests stop, then drains in order.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("full_req_valid", 32'(imem_req_valid), 32'h0);
    check("full_if_valid", 32'(if_valid), 32'h1);
    idle(6);

    // Misaligned jump: single fault pulse, aligned restart.
    fault_cnt = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h202);
    run_until_hs("jump_addr", 32'h200);
    idle(3);
    check("fault_pulses", 32'(fault_cnt), 32'h1);

    // Branch takes priority over a simultaneous jump.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
    run_until_hs("prio_addr", 32'h40);

    // PC wrap from the top of the address space.
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    run_until_hs("wrap_top", 32'hFFFF_FFFC);
    run_until_hs("wrap_zero", 32'h0);

    // Reset in the middle of an outstanding request.
    lat_min = 3; lat_max = 3;
    wait_pending("midwait", 32'h0, 1'b1);
    @(negedge clk);
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; if_ready = 1'b0;
    br_taken = 1'b0; jump = 1'b0; stall = 1'b0;
    #1;
    check_reset_outputs("midrst");
    pend = 1'b0; exp_req = 32'h0; exp_dec = 32'h0; mcount = 0; epoch++; fault_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lat_min = 0; lat_max = 0;
    run_until_hs("post_rst_addr", 32'h0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      int r;
      if (c % 300 == 0) begin
        lat_min = 0;
        lat_max = $urandom_range(0, 3);
      end
      r = $urandom_range(0, 49);
      step($urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
           (r == 0) || (r == 1), rand_target(), (r == 1) || (r == 2), rand_target());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
